// File: rtl/bus_arbiter.sv
// Round-robin arbiter for a shared tristate bus. Grant and oe are registered
// and one-hot; an all-off turnaround separates consecutive owners.
module bus_arbiter #(
    parameter int N          = 4,
    parameter int HOLD_MAX   = 8,
    parameter int TURNAROUND = 1
) (
    input  logic                 Clock,
    input  logic                 nReset,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         grant,
    output logic [N-1:0]         oe,
    output logic [$clog2(N)-1:0] owner,
    output logic                 busy
);
    localparam int OW = $clog2(N);
    localparam int HW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam int TW = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);
    localparam logic [TW-1:0] TURN_LAST = TW'(TURNAROUND - 1);
    localparam logic [N-1:0]  ONE       = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, GRANT, OWN, TURN} state_t;

    state_t        state_q, state_n;
    logic [N-1:0]  grant_n, oe_n;
    logic [OW-1:0] owner_n, ptr_q, ptr_n;
    logic [HW-1:0] hold_q, hold_n;
    logic [TW-1:0] turn_q, turn_n;

    logic [2*N-1:0] req_rot_w;
    logic [N-1:0]   req_rot;
    logic [OW-1:0]  win_off, win, next_ptr;
    logic [OW:0]    win_sum;
    logic           win_vld, owner_req, others;

    // Rotate so the scan always starts at bit 0, then map the offset back.
    always_comb begin
        req_rot_w = {req, req} >> ptr_q;
        req_rot   = req_rot_w[N-1:0];
        win_vld   = |req_rot;
        win_off   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_rot[i]) win_off = OW'(i);
        end
        win_sum = {1'b0, ptr_q} + {1'b0, win_off};
        if (win_sum >= (OW+1)'(N)) win_sum = win_sum - (OW+1)'(N);
        win = win_sum[OW-1:0];
    end

    // grant is one-hot on the owner in GRANT/OWN, so masking avoids indexing.
    assign owner_req = |(req & grant);
    assign others    = |(req & ~grant);
    assign next_ptr  = (owner == OW'(N - 1)) ? '0 : owner + 1'b1;

    always_comb begin
        state_n = state_q;
        grant_n = grant;
        oe_n    = oe;
        owner_n = owner;
        ptr_n   = ptr_q;
        hold_n  = hold_q;
        turn_n  = turn_q;
        unique case (state_q)
            IDLE: begin
                grant_n = '0;
                oe_n    = '0;
                if (win_vld) begin
                    state_n = GRANT;
                    grant_n = ONE << win;
                    owner_n = win;
                end
            end
            GRANT: begin
                oe_n = '0;
                if (owner_req) begin
                    state_n = OWN;
                    oe_n    = grant;
                    hold_n  = '0;
                end else begin
                    state_n = TURN;
                    grant_n = '0;
                    turn_n  = '0;
                end
            end
            OWN: begin
                oe_n = grant;
                if (!owner_req || (hold_q == HOLD_LAST && others)) begin
                    state_n = TURN;
                    grant_n = '0;
                    oe_n    = '0;
                    ptr_n   = next_ptr;
                    turn_n  = '0;
                end else if (hold_q != HOLD_LAST) begin
                    hold_n = hold_q + 1'b1;
                end
            end
            TURN: begin
                grant_n = '0;
                oe_n    = '0;
                if (turn_q == TURN_LAST) state_n = IDLE;
                else                     turn_n  = turn_q + 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q <= IDLE;
            grant   <= '0;
            oe      <= '0;
            owner   <= '0;
            busy    <= 1'b0;
            ptr_q   <= '0;
            hold_q  <= '0;
            turn_q  <= '0;
        end else begin
            state_q <= state_n;
            grant   <= grant_n;
            oe      <= oe_n;
            owner   <= owner_n;
            busy    <= (state_n != IDLE);
            ptr_q   <= ptr_n;
            hold_q  <= hold_n;
            turn_q  <= turn_n;
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: a tenure-level model predicts outputs each
// edge, a monitor compares them and logs oe pulses for directed checks.
module tb_bus_arbiter;
    localparam int N = 4, HOLD_MAX = 8, TURNAROUND = 1, OW = 2;

    logic          Clock = 1'b0;
    logic          nReset = 1'b0;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  grant, oe;
    logic [OW-1:0] owner;
    logic          busy;

    bus_arbiter #(.N(N), .HOLD_MAX(HOLD_MAX), .TURNAROUND(TURNAROUND)) dut (
        .Clock(Clock), .nReset(nReset), .req(req),
        .grant(grant), .oe(oe), .owner(owner), .busy(busy)
    );

    initial forever #5 Clock = ~Clock;

    typedef struct packed {
        logic [N-1:0]  g;
        logic [N-1:0]  o;
        logic [OW-1:0] w;
        logic          b;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0, fails = 0;
    int   ten_own[$], ten_len[$], ten_gap[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return p;
    endfunction

    // Reference model: who holds the bus, whether it is driving, how many
    // cycles it has driven, and how much of the turnaround gap is left.
    int m_ptr = 0, m_owner = 0, m_k = 0, m_turn = 0;
    bit m_grant = 0, m_drive = 0;

    initial begin
        logic [N-1:0] mask;
        exp_t e;
        forever begin
            @(posedge Clock or negedge nReset);
            if (!nReset) begin
                m_ptr = 0; m_owner = 0; m_k = 0; m_turn = 0;
                m_grant = 0; m_drive = 0;
                exp_q.delete();
            end else begin
                mask = '0;
                mask[m_owner] = 1'b1;
                if (m_turn > 0) begin
                    m_turn--;
                end else if (!m_grant) begin
                    if (req != 0) begin
                        m_owner = pick(req, m_ptr);
                        m_grant = 1;
                    end
                end else if (!m_drive) begin
                    if (req[m_owner]) begin
                        m_drive = 1;
                        m_k = 0;
                    end else begin
                        m_grant = 0;
                        m_turn = TURNAROUND;
                    end
                end else begin
                    m_k++;
                    if (!req[m_owner] || (m_k >= HOLD_MAX && (req & ~mask) != 0)) begin
                        m_ptr = (m_owner + 1) % N;
                        m_grant = 0;
                        m_drive = 0;
                        m_turn = TURNAROUND;
                    end
                end
                mask = '0;
                mask[m_owner] = 1'b1;
                e.g = m_grant ? mask : '0;
                e.o = m_drive ? mask : '0;
                e.w = OW'(m_owner);
                e.b = m_grant || (m_turn > 0);
                exp_q.push_back(e);
            end
        end
    end

    // Monitor: compare on the falling edge and record oe pulses.
    initial begin
        exp_t e;
        bit   prev_on = 0;
        int   run_len = 0, low_len = 0, idx;
        forever begin
            @(negedge Clock);
            if (!nReset) begin
                prev_on = 0; run_len = 0; low_len = 0;
            end else begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("cycle{grant,oe,owner,busy}", {grant, oe, owner, busy}, {e.g, e.o, e.w, e.b});
                end
                check("oe_onehot0", $onehot0(oe), 1);
                check("grant_onehot0", $onehot0(grant), 1);
                check("oe_implies_grant", oe & ~grant, 0);
                if (oe != 0) begin
                    if (!prev_on) begin
                        idx = 0;
                        for (int i = 0; i < N; i++) if (oe[i]) idx = i;
                        ten_own.push_back(idx);
                        ten_gap.push_back(low_len);
                        run_len = 0;
                    end
                    run_len++;
                    prev_on = 1;
                end else begin
                    if (prev_on) begin
                        ten_len.push_back(run_len);
                        low_len = 0;
                    end
                    low_len++;
                    prev_on = 0;
                end
            end
        end
    end

    task automatic drive(input logic [N-1:0] r, input int cyc);
        req = r;
        repeat (cyc) @(posedge Clock);
        #1;
    endtask

    task automatic clear_log();
        ten_own.delete(); ten_len.delete(); ten_gap.delete();
    endtask

    // Assert reset mid-cycle, check outputs drop before any edge, release
    // one tick after a rising edge with req_after already applied.
    task automatic pulse_reset(input logic [N-1:0] req_after);
        @(negedge Clock);
        #2;
        nReset = 1'b0;
        #1;
        check("rst_grant", grant, 0);
        check("rst_oe", oe, 0);
        check("rst_owner", owner, 0);
        check("rst_busy", busy, 0);
        req = req_after;
        clear_log();
        repeat (2) @(posedge Clock);
        #1;
        nReset = 1'b1;
    endtask

    initial begin
        logic [N-1:0] r;
        #3;
        check("init_grant", grant, 0);
        check("init_oe", oe, 0);
        check("init_busy", busy, 0);
        @(posedge Clock);
        #1;
        nReset = 1'b1;
        drive('0, 3);

        // Single requester held for 5 OWN cycles.
        clear_log();
        drive(4'b0100, 1);
        check("single_grant_edge1", grant, 4'b0100);
        check("single_oe_edge1", oe, 0);
        drive(4'b0100, 1);
        check("single_oe_edge2", oe, 4'b0100);
        drive(4'b0100, 4);
        drive('0, 1);
        check("single_turn_oe", oe, 0);
        check("single_turn_busy", busy, 1);
        drive('0, 2);
        check("single_idle_busy", busy, 0);
        check("single_pulses", ten_len.size(), 1);
        check("single_owner", ten_own[0], 2);
        check("single_len", ten_len[0], 5);
        drive('0, 4);

        // All four requesting from reset: strict rotation, 8-cycle holds.
        pulse_reset(4'b1111);
        drive(4'b1111, 60);
        drive('0, 15);
        check("rr_pulses_min5", ten_len.size() >= 5, 1);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("rr_owner%0d", i), ten_own[i], i % N);
            check($sformatf("rr_len%0d", i), ten_len[i], HOLD_MAX);
            if (i > 0) check($sformatf("rr_gap%0d", i), ten_gap[i], TURNAROUND + 2);
        end

        // Hold limit: agent 1 arrives during agent 0's third OWN cycle.
        clear_log();
        drive(4'b0001, 4);
        drive(4'b0011, 25);
        drive('0, 10);
        check("hold_owner0", ten_own[0], 0);
        check("hold_len0", ten_len[0], HOLD_MAX);
        check("hold_owner1", ten_own[1], 1);
        check("hold_gap1", ten_gap[1], TURNAROUND + 2);

        // Sole long owner is never forced off.
        clear_log();
        drive(4'b0001, 20);
        drive('0, 6);
        check("sole_pulses", ten_len.size(), 1);
        check("sole_len", ten_len[0], 19);

        // Reset while agent 2 owns the bus; scan restarts at 0.
        drive(4'b0100, 4);
        check("pre_rst_oe", oe, 4'b0100);
        pulse_reset(4'b1100);
        drive(4'b1100, 4);
        check("post_rst_first_owner", ten_own[0], 2);
        drive('0, 25);

        // Random level-held requests, including short pulses and drops.
        r = '0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 5) == 0) r[i] = ~r[i];
            drive(r, 1);
        end
        drive('0, 20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
